apb_uart_csr: RTL
=================

Name: apb_uart_csr

Overview:
Parametrised APB3 completer holding the UART control/status register file. Adds programmable wait states, PSLVERR, a W1C interrupt status register and a masked interrupt output (uart_int). Sits between the APB bus (driven by the APB agent in test) and the UART core. Generalises width, register count and interrupt-source count.

Parameters:
ADDR_W, 12, paddr width in bits.
DATA_W, 32, pwdata/prdata width; one of 8, 16 or 32.
NUM_IRQ, 4, interrupt source count; 1..DATA_W.
NUM_GP, 4, general-purpose RW registers; 1..16.
WAIT_STATES, 0, pready-low cycles inserted in ACCESS; 0..15.
VERSION, 32'h0001_0200, value of the read-only VERSION register, truncated to DATA_W.

Ports:
pclk  in  1  clock.
preset  in  1  asynchronous, active-high reset.
paddr  in  ADDR_W  byte address.
psel  in  1  select.
penable  in  1  enable (access phase).
pwrite  in  1  1 = write.
pwdata  in  DATA_W  write data.
prdata  out  DATA_W  read data; valid only while pready=1, otherwise 0.
pready  out  1  transfer complete.
pslverr  out  1  error; valid only with pready=1.
irq_src  in  NUM_IRQ  one-cycle-or-longer set pulses, one per interrupt source.
ctrl_o  out  DATA_W  CTRL register contents.
gp_o  out  NUM_GP*DATA_W  GP registers, flattened; reg k occupies bits [k*DATA_W +: DATA_W].
uart_int  out  1  registered OR of (INT_STAT & INT_EN).

Behaviour:
- Reset: all registers 0; prdata=0, pready=0, pslverr=0, uart_int=0; FSM=IDLE. Reset is asynchronous and active-high, asserted anywhere mid-transfer; no write commits.
- Word index = paddr >> log2(DATA_W/8).
- Register map by index:
  - 0 CTRL: RW.
  - 1 INT_EN: RW; only the low NUM_IRQ bits are stored.
  - 2 INT_STAT: read; a write of 1 clears that bit (W1C).
  - 3 VERSION: RO.
  - 4..4+NUM_GP-1: GP, RW.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE: psel=1 & penable=0 → capture address, direction and data. Go to WAIT with count=WAIT_STATES, or to ACCESS if WAIT_STATES=0.
  - WAIT: pready=0. Decrement count each cycle; at 1 go to ACCESS.
  - ACCESS: pready=1 for exactly one cycle. A write commits on this edge; prdata and pslverr are driven in this cycle. Next state is IDLE.
  - Latency: pready is asserted WAIT_STATES+1 cycles after the setup cycle.
- Back-to-back transfers are supported. A setup in the cycle after ACCESS is accepted from IDLE with no bubble beyond the APB protocol.
- psel dropping during WAIT aborts to IDLE: no commit, pready stays 0.
- pslverr=1 (with pready=1; no state change; prdata=0) when any of these holds:
  - index beyond the map;
  - paddr not word-aligned;
  - write to VERSION.
- INT_STAT update each cycle: stat_next = (stat & ~w1c_mask) | irq_src. If a set and a clear hit the same bit in the same cycle, the set wins.
- uart_int is registered: it changes one cycle after INT_STAT or INT_EN changes.
- Unused upper bits of INT_EN and INT_STAT read as 0.

Optional Feature:
APB_PSTRB_EN:
- Defined: adds port pstrb (in, DATA_W/8) and the block becomes APB4. On a RW write, byte lane i updates only if pstrb[i]=1. On INT_STAT, W1C applies only to strobed lanes.
- Undefined: no pstrb port; all lanes are written.

Decomposition:
- Package apb_uart_pkg:
  - register index localparams: IDX_CTRL, IDX_INT_EN, IDX_INT_STAT, IDX_VERSION, IDX_GP0;
  - FSM state enum apb_state_e;
  - function addr_to_idx.
- One sub-module, apb_uart_irq: INT_STAT set/W1C logic, masking and the registered uart_int. It is parametrised by NUM_IRQ and DATA_W.

Test Plan:
- WAIT_STATES=2: write 0xA5A5_0001 to 0x000 → pready high on the 3rd cycle after setup; ctrl_o=0xA5A5_0001; a readback returns the same value with pslverr=0.
- irq_src[2] pulsed, INT_EN=0x4 → INT_STAT=0x4; uart_int=1 one cycle later. Write 0x4 to 0x008 → INT_STAT=0, then uart_int=0.
- Write 0x4 to INT_STAT in the same cycle irq_src[2]=1 → INT_STAT bit 2 stays 1.
- Out-of-range access: read 0x100, or write 0x00C (VERSION) → pslverr=1 with pready; registers unchanged. Read 0x00C → prdata=0x0001_0200, pslverr=0.
- Assert preset during WAIT of a GP0 write of 0xFFFF_FFFF → gp_o=0, pready=0; the next transfer completes normally.
- APB_PSTRB_EN: GP0=0x1122_3344, write 0xAABB_CCDD with pstrb=4'b0101 → GP0=0x11BB_33DD.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART control/status register block:
// register indices, transfer FSM states and address-to-index decoding.
package apb_uart_pkg;

    localparam int IDX_CTRL     = 0;
    localparam int IDX_INT_EN   = 1;
    localparam int IDX_INT_STAT = 2;
    localparam int IDX_VERSION  = 3;
    localparam int IDX_GP0      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Byte address to word index; byte_lsb is log2 of the bus width in bytes.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                                input int unsigned byte_lsb);
        return addr >> byte_lsb;
    endfunction

endpackage

// File: rtl/apb_uart_irq.sv
// Interrupt status (sticky set, write-one-to-clear) and the registered,
// enable-masked uart_int output.
import apb_uart_pkg::*;

module apb_uart_irq #(
    parameter int NUM_IRQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] int_en,
    input  logic               w1c_en,
    input  logic [NUM_IRQ-1:0] w1c_mask,
    output logic [DATA_W-1:0]  int_stat,
    output logic               uart_int
);

    logic [NUM_IRQ-1:0] stat_reg;
    logic [NUM_IRQ-1:0] stat_next;
    logic [NUM_IRQ-1:0] clr_mask;
    logic               uart_int_reg;

    // A set arriving in the same cycle as a clear of that bit wins.
    assign clr_mask  = w1c_en ? w1c_mask : '0;
    assign stat_next = (stat_reg & ~clr_mask) | irq_src;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            stat_reg     <= '0;
            uart_int_reg <= 1'b0;
        end else begin
            stat_reg     <= stat_next;
            uart_int_reg <= |(stat_reg & int_en);
        end
    end

    assign int_stat = DATA_W'(stat_reg);
    assign uart_int = uart_int_reg;

endmodule

// File: rtl/apb_uart_csr.sv
// APB3 completer for the UART control/status registers with wait states and
// PSLVERR. Define APB_PSTRB_EN to add the APB4 pstrb byte-strobe port.
import apb_uart_pkg::*;

module apb_uart_csr #(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 32,
    parameter int          NUM_IRQ     = 4,
    parameter int          NUM_GP      = 4,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] VERSION     = 32'h0001_0200
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [ADDR_W-1:0]        paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0]      pstrb,
`endif
    input  logic [DATA_W-1:0]        pwdata,
    output logic [DATA_W-1:0]        prdata,
    output logic                     pready,
    output logic                     pslverr,
    input  logic [NUM_IRQ-1:0]       irq_src,
    output logic [DATA_W-1:0]        ctrl_o,
    output logic [NUM_GP*DATA_W-1:0] gp_o,
    output logic                     uart_int
);

    localparam int          NUM_BYTES  = DATA_W / 8;
    localparam int          BYTE_LSB   = $clog2(NUM_BYTES);
    localparam logic [31:0] ALIGN_MASK = 32'(NUM_BYTES - 1);
    localparam logic [31:0] NUM_REGS   = 32'(IDX_GP0 + NUM_GP);
    localparam logic [DATA_W-1:0] VERSION_W = VERSION[DATA_W-1:0];

    apb_state_e state_reg, state_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [31:0]          addr_reg;
    logic                 write_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [NUM_BYTES-1:0] strb_reg;
    logic [NUM_BYTES-1:0] strb_in;

    logic [DATA_W-1:0]    ctrl_reg;
    logic [NUM_IRQ-1:0]   int_en_reg;
    logic [DATA_W-1:0]    gp_reg [NUM_GP];
    logic [DATA_W-1:0]    int_stat;
    logic [DATA_W-1:0]    wmask;
    logic [DATA_W-1:0]    rd_word;
    logic [31:0]          idx;
    logic                 access_err;
    logic                 in_access;
    logic                 commit;
    logic                 setup;

`ifdef APB_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    assign setup = (state_reg == ST_IDLE) && psel && !penable;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (setup) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                // Master withdrawing psel abandons the transfer without a commit.
                if (!psel) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg <= 4'd1) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ACCESS: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            strb_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (setup) begin
                addr_reg  <= 32'(paddr);
                write_reg <= pwrite;
                wdata_reg <= pwdata;
                strb_reg  <= strb_in;
            end
        end
    end

    assign idx        = addr_to_idx(addr_reg, BYTE_LSB);
    assign access_err = (|(addr_reg & ALIGN_MASK)) || (idx >= NUM_REGS) ||
                        (write_reg && (idx == IDX_VERSION));
    assign in_access  = (state_reg == ST_ACCESS);
    assign commit     = in_access && write_reg && !access_err;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{strb_reg[gi]}};
        end
    endgenerate

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_reg   <= '0;
            int_en_reg <= '0;
        end else if (commit) begin
            if (idx == IDX_CTRL)
                ctrl_reg <= (ctrl_reg & ~wmask) | (wdata_reg & wmask);
            if (idx == IDX_INT_EN)
                int_en_reg <= (int_en_reg & ~wmask[NUM_IRQ-1:0]) |
                              (wdata_reg[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0]);
        end
    end

    generate
        for (gi = 0; gi < NUM_GP; gi++) begin : g_gp
            always_ff @(posedge pclk or posedge preset) begin
                if (preset)
                    gp_reg[gi] <= '0;
                else if (commit && (idx == 32'(IDX_GP0 + gi)))
                    gp_reg[gi] <= (gp_reg[gi] & ~wmask) | (wdata_reg & wmask);
            end
            assign gp_o[gi*DATA_W +: DATA_W] = gp_reg[gi];
        end
    endgenerate

    apb_uart_irq #(
        .NUM_IRQ (NUM_IRQ),
        .DATA_W  (DATA_W)
    ) u_irq (
        .pclk     (pclk),
        .preset   (preset),
        .irq_src  (irq_src),
        .int_en   (int_en_reg),
        .w1c_en   (commit && (idx == IDX_INT_STAT)),
        .w1c_mask (wdata_reg[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0]),
        .int_stat (int_stat),
        .uart_int (uart_int)
    );

    always_comb begin
        rd_word = '0;
        if (idx == IDX_CTRL)     rd_word = ctrl_reg;
        if (idx == IDX_INT_EN)   rd_word = DATA_W'(int_en_reg);
        if (idx == IDX_INT_STAT) rd_word = int_stat;
        if (idx == IDX_VERSION)  rd_word = VERSION_W;
        for (int k = 0; k < NUM_GP; k++) begin
            if (idx == 32'(IDX_GP0 + k)) rd_word = gp_reg[k];
        end
    end

    assign prdata  = (in_access && !write_reg && !access_err) ? rd_word : '0;
    assign pready  = in_access;
    assign pslverr = in_access && access_err;
    assign ctrl_o  = ctrl_reg;

endmodule
